except_flush_ctrl: RTL and testbench
====================================

// Module: except_flush_ctrl
// PURPOSE
//  Sequences exception/ERET handling after the M-stage exception priority
//  encoder has produced excepttype. Captures the faulting instruction context,
//  holds it while the memory pipeline is stalled, commits it to CP0 once,
//  then flushes the pipeline and redirects fetch to the vector or EPC.
//  Sits between the M-stage excepttype and the CP0, hazard and PC-select logic.
// PARAMETERS
//  EXC_VEC      32'hBFC00380  general exception vector (BEV=1)
//  REFILL_VEC   32'hBFC00200  TLB refill vector (types 0x10, 0x11)
//  ERET_CODE    32'h0000000E  excepttype value meaning ERET
//  FLUSH_CYCLES 2             cycles flush_o stays high (>=1)
// PORTS
//  clk            in   1   clock
//  resetn         in   1   synchronous reset, active-low
//  excepttype_i   in   32  encoded exception type from M stage, 0 = none
//  pc_i           in   32  PC of M-stage instruction
//  in_delayslot_i in   1   M-stage instruction is in a branch delay slot
//  cp0_epc_i      in   32  current CP0 EPC (ERET target)
//  stall_i        in   1   M stage stalled (memory wait)
//  cp0_exc_we_o   out  1   one-cycle pulse: write EPC/Cause.BD/ExcCode, set EXL
//  cp0_excode_o   out  5   Cause.ExcCode to write
//  cp0_epc_o      out  32  EPC value to write
//  cp0_bd_o       out  1   Cause.BD value to write
//  eret_o         out  1   one-cycle pulse: clear Status.EXL
//  flush_o        out  1   flush all pipeline stages
//  newpc_valid_o  out  1   one-cycle pulse: fetch must take newpc_o
//  newpc_o        out  32  redirect target
//  busy_o         out  1   state != IDLE
//  exc_cnt_o      out  8   count of committed exceptions + ERETs (wraps)
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state IDLE, all outputs 0, exc_cnt_o=0,
//   captured context cleared; applies even mid-sequence.
//  States: IDLE, HOLD, COMMIT, FLUSH.
//  IDLE: excepttype_i!=0 sampled -> capture type, pc, bd; go HOLD if
//   stall_i=1, else COMMIT. excepttype_i ignored in all other states.
//  HOLD: wait while stall_i=1; stall_i=0 -> COMMIT. No outputs asserted
//   except busy_o. Captured context never changes in HOLD.
//  COMMIT (exactly 1 cycle): flush_o=1, newpc_valid_o=1, exc_cnt_o+=1.
//   ERET type: eret_o=1, newpc_o=cp0_epc_i (sampled this cycle), no CP0 write.
//   Other types: cp0_exc_we_o=1; cp0_bd_o=bd; cp0_epc_o = bd ? pc-4 : pc
//   (mod 2^32: pc=0 -> 32'hFFFFFFFC); newpc_o = REFILL_VEC for 0x10/0x11,
//   else EXC_VEC.
//   -> FLUSH if FLUSH_CYCLES>1, else IDLE.
//  FLUSH: flush_o=1 for FLUSH_CYCLES-1 cycles (down-counter), then IDLE.
//   stall_i has no effect in COMMIT/FLUSH.
//  ExcCode map: 0x01->0 Int, 0x04->4 AdEL, 0x05->5 AdES, 0x08->8 Sys,
//   0x09->9 Bp, 0x0A->10 RI, 0x0B->11 CpU, 0x0C->12 Ov, 0x0D->13 Tr,
//   0x10/0x12->2 TLBL, 0x11/0x13->3 TLBS, 0x14->1 Mod; other nonzero -> 10 RI.
//  Latency: excepttype at posedge N, no stall -> COMMIT outputs during N+1.
//  Back-to-back: new exception accepted the first cycle back in IDLE.
//  newpc_o, cp0_* hold last values outside COMMIT; consumers qualify with
//   pulses.
// TESTING
//  1 type=0x04, pc=0x80001000, bd=0, no stall -> next cycle we=1, excode=4,
//    epc=0x80001000, newpc=0xBFC00380, flush 2 cycles, cnt=1.
//  2 type=0x0C, pc=0x80002008, bd=1, stall 3 cycles -> busy 3 cycles in HOLD,
//    then we=1, excode=12, epc=0x80002004, bd=1.
//  3 type=0x0E (ERET), cp0_epc=0x80003000 -> eret_o=1, we=0,
//    newpc=0x80003000, flush_o=1.
//  4 type=0x10, pc=0 bd=1 -> excode=2, epc=0xFFFFFFFC, newpc=0xBFC00200.
//  5 type=0x01 then type=0x08 during FLUSH -> only Int(excode 0) committed;
//    0x08 ignored; 0x08 re-presented in IDLE -> excode 8, cnt=2.
//  6 resetn=0 during HOLD -> next cycle IDLE, busy=0, no we pulse; 256 commits
//    -> exc_cnt_o wraps to 0.

Source files
------------

// File: rtl/except_flush_ctrl.sv
// except_flush_ctrl
// Sequences exception and ERET handling once the M-stage priority encoder has
// produced excepttype. It captures the faulting context, waits out memory
// stalls, commits to CP0 in a single cycle, then flushes the pipeline and
// redirects fetch to the exception vector or to EPC.
module except_flush_ctrl #(
  parameter logic [31:0] EXC_VEC      = 32'hBFC00380,
  parameter logic [31:0] REFILL_VEC   = 32'hBFC00200,
  parameter logic [31:0] ERET_CODE    = 32'h0000000E,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        stall_i,
  output logic        cp0_exc_we_o,
  output logic [4:0]  cp0_excode_o,
  output logic [31:0] cp0_epc_o,
  output logic        cp0_bd_o,
  output logic        eret_o,
  output logic        flush_o,
  output logic        newpc_valid_o,
  output logic [31:0] newpc_o,
  output logic        busy_o,
  output logic [7:0]  exc_cnt_o
);

  // The flush down-counter only needs to hold FLUSH_CYCLES-1.
  localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_COMMIT = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  state_t            r_state;

  // Captured faulting-instruction context
  logic [31:0]       r_type;
  logic [31:0]       r_pc;
  logic              r_bd;
  logic [FC_W-1:0]   r_fcnt;

  // Registered outputs
  logic              r_cp0_we;
  logic [4:0]        r_excode;
  logic [31:0]       r_epc;
  logic              r_bd_out;
  logic              r_eret;
  logic              r_flush;
  logic              r_npc_vld;
  logic [31:0]       r_npc;
  logic              r_busy;
  logic [7:0]        r_cnt;

  // Context as seen by the commit logic: the live inputs when committing
  // straight out of IDLE, otherwise the captured copy.
  logic [31:0]       w_type;
  logic [31:0]       w_pc;
  logic              w_bd;
  logic              w_go_commit;
  logic              w_is_eret;
  logic              w_is_refill;
  logic [31:0]       w_epc_calc;
  logic [4:0]        w_excode;

  // Maps the encoded exception type onto Cause.ExcCode.
  function automatic logic [4:0] f_excode(input logic [31:0] t);
    logic [4:0] c;
    case (t)
      32'h01:          c = 5'd0;   // Int
      32'h04:          c = 5'd4;   // AdEL
      32'h05:          c = 5'd5;   // AdES
      32'h08:          c = 5'd8;   // Sys
      32'h09:          c = 5'd9;   // Bp
      32'h0A:          c = 5'd10;  // RI
      32'h0B:          c = 5'd11;  // CpU
      32'h0C:          c = 5'd12;  // Ov
      32'h0D:          c = 5'd13;  // Tr
      32'h10, 32'h12:  c = 5'd2;   // TLBL (refill / invalid)
      32'h11, 32'h13:  c = 5'd3;   // TLBS (refill / invalid)
      32'h14:          c = 5'd1;   // Mod
      default:         c = 5'd10;  // unknown codes reported as RI
    endcase
    return c;
  endfunction

  // EPC points at the branch when the faulting instruction sits in a delay slot.
  function automatic logic [31:0] f_epc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  // Commit source selection and decode.
  always_comb begin
    w_type      = r_type;
    w_pc        = r_pc;
    w_bd        = r_bd;
    if (r_state == S_IDLE) begin
      w_type = excepttype_i;
      w_pc   = pc_i;
      w_bd   = in_delayslot_i;
    end
    w_go_commit = ((r_state == S_IDLE) && (excepttype_i != 32'd0) && !stall_i) ||
                  ((r_state == S_HOLD) && !stall_i);
    w_is_eret   = (w_type == ERET_CODE);
    w_is_refill = (w_type == 32'h10) || (w_type == 32'h11);
    w_epc_calc  = f_epc(w_pc, w_bd);
    w_excode    = f_excode(w_type);
  end

  // Sequencer FSM with registered outputs. Entry into COMMIT is handled after
  // the case statement so IDLE and HOLD share one commit path; its
  // assignments take precedence over the per-state ones.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_type    <= 32'd0;
      r_pc      <= 32'd0;
      r_bd      <= 1'b0;
      r_fcnt    <= '0;
      r_cp0_we  <= 1'b0;
      r_excode  <= 5'd0;
      r_epc     <= 32'd0;
      r_bd_out  <= 1'b0;
      r_eret    <= 1'b0;
      r_flush   <= 1'b0;
      r_npc_vld <= 1'b0;
      r_npc     <= 32'd0;
      r_busy    <= 1'b0;
      r_cnt     <= 8'd0;
    end else begin
      r_cp0_we  <= 1'b0;
      r_eret    <= 1'b0;
      r_npc_vld <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (excepttype_i != 32'd0) begin
            r_type <= excepttype_i;
            r_pc   <= pc_i;
            r_bd   <= in_delayslot_i;
            if (stall_i) begin
              r_state <= S_HOLD;
              r_busy  <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          r_busy <= 1'b1;
        end
        S_COMMIT: begin
          if (FLUSH_CYCLES > 1) begin
            r_state <= S_FLUSH;
            r_fcnt  <= FC_W'(FLUSH_CYCLES - 1);
          end else begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_fcnt <= FC_W'(1)) begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt - FC_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_flush <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_go_commit) begin
        r_state   <= S_COMMIT;
        r_busy    <= 1'b1;
        r_flush   <= 1'b1;
        r_npc_vld <= 1'b1;
        r_cnt     <= r_cnt + 8'd1;
        if (w_is_eret) begin
          r_eret <= 1'b1;
          r_npc  <= cp0_epc_i;
        end else begin
          r_cp0_we <= 1'b1;
          r_excode <= w_excode;
          r_epc    <= w_epc_calc;
          r_bd_out <= w_bd;
          r_npc    <= w_is_refill ? REFILL_VEC : EXC_VEC;
        end
      end
    end
  end

  assign cp0_exc_we_o  = r_cp0_we;
  assign cp0_excode_o  = r_excode;
  assign cp0_epc_o     = r_epc;
  assign cp0_bd_o      = r_bd_out;
  assign eret_o        = r_eret;
  assign flush_o       = r_flush;
  assign newpc_valid_o = r_npc_vld;
  assign newpc_o       = r_npc;
  assign busy_o        = r_busy;
  assign exc_cnt_o     = r_cnt;

endmodule

// File: tb/tb_except_flush_ctrl.sv
// Directed testbench for except_flush_ctrl with hand-computed expectations.
module tb_except_flush_ctrl;

  localparam logic [31:0] EXC_VEC    = 32'hBFC00380;
  localparam logic [31:0] REFILL_VEC = 32'hBFC00200;

  logic        clk;
  logic        resetn;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] cp0_epc_i;
  logic        stall_i;
  logic        cp0_exc_we_o;
  logic [4:0]  cp0_excode_o;
  logic [31:0] cp0_epc_o;
  logic        cp0_bd_o;
  logic        eret_o;
  logic        flush_o;
  logic        newpc_valid_o;
  logic [31:0] newpc_o;
  logic        busy_o;
  logic [7:0]  exc_cnt_o;

  int checks;
  int errors;
  logic [7:0] exp_cnt;

  except_flush_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .excepttype_i   (excepttype_i),
    .pc_i           (pc_i),
    .in_delayslot_i (in_delayslot_i),
    .cp0_epc_i      (cp0_epc_i),
    .stall_i        (stall_i),
    .cp0_exc_we_o   (cp0_exc_we_o),
    .cp0_excode_o   (cp0_excode_o),
    .cp0_epc_o      (cp0_epc_o),
    .cp0_bd_o       (cp0_bd_o),
    .eret_o         (eret_o),
    .flush_o        (flush_o),
    .newpc_valid_o  (newpc_valid_o),
    .newpc_o        (newpc_o),
    .busy_o         (busy_o),
    .exc_cnt_o      (exc_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the COMMIT-cycle view of a non-ERET exception.
  task automatic chk_commit(input string tag, input logic [4:0] exc, input logic [31:0] epc,
                            input logic bd, input logic [31:0] npc);
    chk({tag, "_we"},     {31'd0, cp0_exc_we_o}, 32'd1);
    chk({tag, "_excode"}, {27'd0, cp0_excode_o}, {27'd0, exc});
    chk({tag, "_epc"},    cp0_epc_o, epc);
    chk({tag, "_bd"},     {31'd0, cp0_bd_o}, {31'd0, bd});
    chk({tag, "_newpc"},  newpc_o, npc);
    chk({tag, "_vld"},    {31'd0, newpc_valid_o}, 32'd1);
    chk({tag, "_flush"},  {31'd0, flush_o}, 32'd1);
    chk({tag, "_eret"},   {31'd0, eret_o}, 32'd0);
    chk({tag, "_cnt"},    {24'd0, exc_cnt_o}, {24'd0, exp_cnt});
  endtask

  // Runs the two post-commit cycles (FLUSH, back to IDLE) and checks them.
  task automatic drain(input string tag);
    tick();
    chk({tag, "_fl_flush"}, {31'd0, flush_o}, 32'd1);
    chk({tag, "_fl_we"},    {31'd0, cp0_exc_we_o}, 32'd0);
    chk({tag, "_fl_vld"},   {31'd0, newpc_valid_o}, 32'd0);
    tick();
    chk({tag, "_idle_flush"}, {31'd0, flush_o}, 32'd0);
    chk({tag, "_idle_busy"},  {31'd0, busy_o}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] t;
    logic [4:0]  exc;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 8'd0;
    resetn = 1'b0;
    excepttype_i = 32'd0;
    pc_i = 32'd0;
    in_delayslot_i = 1'b0;
    cp0_epc_i = 32'd0;
    stall_i = 1'b0;

    tbl[0] = '{32'h05, 5'd5,  EXC_VEC};
    tbl[1] = '{32'h09, 5'd9,  EXC_VEC};
    tbl[2] = '{32'h0A, 5'd10, EXC_VEC};
    tbl[3] = '{32'h0B, 5'd11, EXC_VEC};
    tbl[4] = '{32'h0D, 5'd13, EXC_VEC};
    tbl[5] = '{32'h11, 5'd3,  REFILL_VEC};
    tbl[6] = '{32'h12, 5'd2,  EXC_VEC};
    tbl[7] = '{32'h13, 5'd3,  EXC_VEC};
    tbl[8] = '{32'h14, 5'd1,  EXC_VEC};
    tbl[9] = '{32'h3F, 5'd10, EXC_VEC};

    // Reset state
    tick();
    tick();
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_we",    {31'd0, cp0_exc_we_o}, 32'd0);
    chk("rst_cnt",   {24'd0, exc_cnt_o}, 32'd0);
    chk("rst_newpc", newpc_o, 32'd0);
    resetn = 1'b1;
    tick();
    chk("idle_busy", {31'd0, busy_o}, 32'd0);

    // 1: AdEL, no stall; stall raised during FLUSH must not extend it
    excepttype_i = 32'h04; pc_i = 32'h80001000; in_delayslot_i = 1'b0;
    tick();
    excepttype_i = 32'd0;
    exp_cnt = 8'd1;
    chk_commit("t1", 5'd4, 32'h80001000, 1'b0, EXC_VEC);
    stall_i = 1'b1;
    drain("t1");
    stall_i = 1'b0;
    chk("t1_hold_newpc", newpc_o, EXC_VEC);

    // 2: Ov in delay slot, stalled 3 cycles; context must not follow inputs
    excepttype_i = 32'h0C; pc_i = 32'h80002008; in_delayslot_i = 1'b1; stall_i = 1'b1;
    tick();
    excepttype_i = 32'h04; pc_i = 32'h12345678; in_delayslot_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_busy", {31'd0, busy_o}, 32'd1);
      chk("t2_hold_we",   {31'd0, cp0_exc_we_o}, 32'd0);
      chk("t2_hold_fl",   {31'd0, flush_o}, 32'd0);
      if (i < 2) tick();
    end
    stall_i = 1'b0;
    tick();
    excepttype_i = 32'd0;
    exp_cnt = 8'd2;
    chk_commit("t2", 5'd12, 32'h80002004, 1'b1, EXC_VEC);
    drain("t2");

    // 3: ERET
    excepttype_i = 32'h0E; cp0_epc_i = 32'h80003000;
    tick();
    excepttype_i = 32'd0;
    exp_cnt = 8'd3;
    chk("t3_eret",  {31'd0, eret_o}, 32'd1);
    chk("t3_we",    {31'd0, cp0_exc_we_o}, 32'd0);
    chk("t3_newpc", newpc_o, 32'h80003000);
    chk("t3_vld",   {31'd0, newpc_valid_o}, 32'd1);
    chk("t3_flush", {31'd0, flush_o}, 32'd1);
    chk("t3_cnt",   {24'd0, exc_cnt_o}, {24'd0, exp_cnt});
    chk("t3_epc_held", cp0_epc_o, 32'h80002004);
    drain("t3");
    chk("t3_eret_pulse", {31'd0, eret_o}, 32'd0);

    // 4: TLB refill load, pc=0 in delay slot
    excepttype_i = 32'h10; pc_i = 32'd0; in_delayslot_i = 1'b1;
    tick();
    excepttype_i = 32'd0;
    exp_cnt = 8'd4;
    chk_commit("t4", 5'd2, 32'hFFFFFFFC, 1'b1, REFILL_VEC);
    drain("t4");

    // 5: Int, then Sys presented during FLUSH is ignored, accepted once idle
    excepttype_i = 32'h01; pc_i = 32'h80004000; in_delayslot_i = 1'b0;
    tick();
    excepttype_i = 32'h08; pc_i = 32'h80004100;
    exp_cnt = 8'd5;
    chk_commit("t5a", 5'd0, 32'h80004000, 1'b0, EXC_VEC);
    tick();
    chk("t5_fl_we",  {31'd0, cp0_exc_we_o}, 32'd0);
    chk("t5_fl_cnt", {24'd0, exc_cnt_o}, 32'd5);
    tick();
    chk("t5_idle_busy", {31'd0, busy_o}, 32'd0);
    tick();
    excepttype_i = 32'd0;
    exp_cnt = 8'd6;
    chk_commit("t5b", 5'd8, 32'h80004100, 1'b0, EXC_VEC);
    drain("t5b");

    // ExcCode map and vector selection for the remaining codes
    for (int i = 0; i < 10; i++) begin
      excepttype_i = tbl[i].t; pc_i = 32'h80005000 + 32'(i * 4); in_delayslot_i = 1'b0;
      tick();
      excepttype_i = 32'd0;
      exp_cnt = exp_cnt + 8'd1;
      chk_commit($sformatf("map%02h", tbl[i].t[7:0]), tbl[i].exc,
                 32'h80005000 + 32'(i * 4), 1'b0, tbl[i].npc);
      tick();
      tick();
    end

    // 6: reset during HOLD
    excepttype_i = 32'h08; pc_i = 32'h80006000; stall_i = 1'b1;
    tick();
    chk("t6_hold_busy", {31'd0, busy_o}, 32'd1);
    resetn = 1'b0;
    tick();
    excepttype_i = 32'd0; stall_i = 1'b0;
    chk("t6_rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("t6_rst_we",    {31'd0, cp0_exc_we_o}, 32'd0);
    chk("t6_rst_cnt",   {24'd0, exc_cnt_o}, 32'd0);
    chk("t6_rst_epc",   cp0_epc_o, 32'd0);
    resetn = 1'b1;
    tick();
    chk("t6_post_we",   {31'd0, cp0_exc_we_o}, 32'd0);
    chk("t6_post_busy", {31'd0, busy_o}, 32'd0);

    // 256 commits wrap the counter
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      excepttype_i = 32'h01;
      tick();
      excepttype_i = 32'd0;
      exp_cnt = exp_cnt + 8'd1;
      if (i == 254) chk("wrap_255", {24'd0, exc_cnt_o}, 32'd255);
      if (i == 255) chk("wrap_0", {24'd0, exc_cnt_o}, 32'd0);
      tick();
      tick();
    end
    chk("wrap_idle_cnt", {24'd0, exc_cnt_o}, {24'd0, exp_cnt});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
